// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory stage: size encoding, FSM states,
// byte-enable generation, store-lane replication and load lane selection.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [1:0] {IDLE, REQ, RESP} mem_state_t;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: byte_en = 4'b0001 << off;
         SZ_HALF: byte_en = 4'b0011 << {off[1], 1'b0};
         default: byte_en = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         SZ_BYTE: store_lanes = {4{wdata[7:0]}};
         SZ_HALF: store_lanes = {2{wdata[15:0]}};
         default: store_lanes = wdata;
      endcase
   endfunction

   function automatic logic [7:0] lane_byte(input logic [31:0] data, input logic [1:0] lane);
      lane_byte = data[lane*8 +: 8];
   endfunction

   function automatic logic [15:0] lane_half(input logic [31:0] data, input logic hi);
      lane_half = hi ? data[31:16] : data[15:0];
   endfunction

   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         SZ_BYTE: misaligned = 1'b0;
         SZ_HALF: misaligned = off[0];
         default: misaligned = (off != 2'b00);
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/grant/response data bus between the memory stage and the memory system.
interface mem_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a bus word and sign- or zero-extends it.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b    = lane_byte(rdata, addr);
      h    = lane_half(rdata, addr[1]);
      data = rdata;
      case (size)
         SZ_BYTE: data = {{24{~uns & b[7]}}, b};
         SZ_HALF: data = {{16{~uns & h[15]}}, h};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RISC-V memory pipeline stage: passes ALU ops through, runs loads/stores on the
// data bus with a response timeout. Optional macro: MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage
   import mem_pkg::*;
#(
   parameter int RESP_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_mem_rd,
   input  logic        in_mem_wr,
   input  logic [1:0]  in_size,
   input  logic        in_unsigned,
   input  logic [31:0] in_addr,
   input  logic [31:0] in_wdata,
   input  logic [4:0]  in_rd_addr,
   input  logic [31:0] in_rd_val,
   input  logic        in_wb_en,
   mem_stage_if.master dbus,
   output logic        out_valid,
   output logic [4:0]  out_rd_addr,
   output logic [31:0] out_rd_val,
   output logic        out_wb_en,
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   output logic        out_misalign,
`endif
   output logic        out_bus_err
);

   localparam int CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;

   mem_state_t    state, nxt;
   logic [CW-1:0] cnt;
   logic          tmo, accept, is_mem, trap, go_mem;

   logic          we_q, uns_q, wb_q;
   logic [31:0]   addr_q, wdata_q, ld_data;
   logic [3:0]    be_q;
   logic [1:0]    off_q, size_q;
   logic [4:0]    rd_q;

   assign accept = in_valid && in_ready;
   assign is_mem = in_mem_rd || in_mem_wr;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   assign trap   = is_mem && misaligned(in_size, in_addr[1:0]);
`else
   assign trap   = 1'b0;
`endif
   assign go_mem = accept && is_mem && !trap;
   assign tmo    = (RESP_TIMEOUT != 0) && (state != IDLE) && (cnt == CW'(RESP_TIMEOUT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   // Timeout wins over a same-cycle gnt/rvalid: the request is already withdrawn.
   always_comb begin
      nxt      = state;
      in_ready = 1'b0;
      dbus.req = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (go_mem) nxt = REQ;
         end
         REQ: begin
            dbus.req = !tmo;
            if (tmo)           nxt = IDLE;
            else if (dbus.gnt) nxt = we_q ? IDLE : RESP;
         end
         RESP: begin
            if (tmo || dbus.rvalid) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              cnt <= '0;
      else if (state == IDLE || nxt != state) cnt <= '0;
      else                                   cnt <= cnt + CW'(1);
   end

   assign dbus.we    = we_q;
   assign dbus.addr  = addr_q;
   assign dbus.be    = be_q;
   assign dbus.wdata = wdata_q;

   load_align u_align (
      .rdata (dbus.rdata),
      .addr  (off_q),
      .size  (size_q),
      .uns   (uns_q),
      .data  (ld_data)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         we_q         <= 1'b0;
         addr_q       <= '0;
         be_q         <= '0;
         wdata_q      <= '0;
         off_q        <= '0;
         size_q       <= '0;
         uns_q        <= 1'b0;
         rd_q         <= '0;
         wb_q         <= 1'b0;
         out_valid    <= 1'b0;
         out_rd_addr  <= '0;
         out_rd_val   <= '0;
         out_wb_en    <= 1'b0;
         out_bus_err  <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
         out_misalign <= 1'b0;
`endif
      end else begin
         out_valid    <= 1'b0;
         out_bus_err  <= 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
         out_misalign <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (go_mem) begin
                  // A load wins when both rd and wr are set.
                  we_q    <= !in_mem_rd;
                  addr_q  <= {in_addr[31:2], 2'b00};
                  be_q    <= byte_en(in_size, in_addr[1:0]);
                  wdata_q <= store_lanes(in_size, in_wdata);
                  off_q   <= in_addr[1:0];
                  size_q  <= in_size;
                  uns_q   <= in_unsigned;
                  rd_q    <= in_rd_addr;
                  wb_q    <= in_mem_rd && in_wb_en && (in_rd_addr != 5'd0);
               end else if (accept) begin
                  out_valid    <= 1'b1;
                  out_rd_addr  <= in_rd_addr;
                  out_rd_val   <= in_rd_val;
                  out_wb_en    <= !is_mem && in_wb_en && (in_rd_addr != 5'd0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                  out_misalign <= trap;
`endif
               end
            end
            REQ: begin
               if (tmo || (dbus.gnt && we_q)) begin
                  out_valid   <= 1'b1;
                  out_rd_addr <= rd_q;
                  out_rd_val  <= '0;
                  out_wb_en   <= 1'b0;
                  out_bus_err <= tmo;
               end
            end
            RESP: begin
               if (tmo) begin
                  out_valid   <= 1'b1;
                  out_rd_addr <= rd_q;
                  out_rd_val  <= '0;
                  out_wb_en   <= 1'b0;
                  out_bus_err <= 1'b1;
               end else if (dbus.rvalid) begin
                  out_valid   <= 1'b1;
                  out_rd_addr <= rd_q;
                  out_rd_val  <= ld_data;
                  out_wb_en   <= wb_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage (RESP_TIMEOUT = 4); honours MEM_STAGE_MISALIGN_TRAP_EN.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0, in_mem_rd = 1'b0, in_mem_wr = 1'b0, in_unsigned = 1'b0, in_wb_en = 1'b0;
   logic [1:0]  in_size = '0;
   logic [31:0] in_addr = '0, in_wdata = '0, in_rd_val = '0;
   logic [4:0]  in_rd_addr = '0;
   logic        in_ready, out_valid, out_wb_en, out_bus_err;
   logic [4:0]  out_rd_addr;
   logic [31:0] out_rd_val;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic        out_misalign;
`endif

   mem_stage_if bus ();

   mem_stage #(.RESP_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr),
      .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
      .in_rd_addr(in_rd_addr), .in_rd_val(in_rd_val), .in_wb_en(in_wb_en),
      .dbus(bus.master),
      .out_valid(out_valid), .out_rd_addr(out_rd_addr), .out_rd_val(out_rd_val), .out_wb_en(out_wb_en),
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      .out_misalign(out_misalign),
`endif
      .out_bus_err(out_bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
      logic        wb;
      logic        err;
      logic        full;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] val, input logic wb,
                       input logic err, input logic full);
      exp_t e;
      e.rd = rd; e.val = val; e.wb = wb; e.err = err; e.full = full;
      q.push_back(e);
   endtask

   task automatic retire_now(input string tag);
      exp_t e;
      chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      if (out_valid) begin
         chk({tag, "_sb_nonempty"}, q.size(), (q.size() > 0) ? q.size() : 1);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_wb"},  {31'd0, out_wb_en},   {31'd0, e.wb});
            chk({tag, "_err"}, {31'd0, out_bus_err}, {31'd0, e.err});
            if (e.full) begin
               chk({tag, "_rd"},  {27'd0, out_rd_addr}, {27'd0, e.rd});
               chk({tag, "_val"}, out_rd_val, e.val);
            end
         end
      end
   endtask

   task automatic wait_retire(input string tag, input int budget);
      bit seen = 0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (out_valid) begin
            retire_now(tag);
            seen = 1;
         end
      end
      if (!seen) chk({tag, "_seen"}, {31'd0, out_valid}, 32'd1);
   endtask

   task automatic drive_mem(input logic rd_op, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [4:0] rd, input logic [31:0] wdata);
      in_valid = 1; in_mem_rd = rd_op; in_mem_wr = !rd_op; in_size = size; in_unsigned = uns;
      in_addr = addr; in_wdata = wdata; in_rd_addr = rd; in_rd_val = 32'hDEAD_BEEF; in_wb_en = 1;
   endtask

   task automatic idle_in();
      in_valid = 0; in_mem_rd = 0; in_mem_wr = 0;
   endtask

   task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wdata, input int gdly,
                           input logic [3:0] be, input logic [31:0] lanes);
      drive_mem(0, addr, size, 0, 5'd3, wdata);
      push(5'd3, 0, 0, 0, 0);
      @(negedge clk); idle_in();
      for (int i = 0; i < gdly; i++) begin
         chk({tag, "_wait_req"}, {31'd0, bus.req}, 32'd1);
         chk({tag, "_wait_rdy"}, {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      chk({tag, "_req"},   {31'd0, bus.req}, 32'd1);
      chk({tag, "_we"},    {31'd0, bus.we}, 32'd1);
      chk({tag, "_addr"},  bus.addr, {addr[31:2], 2'b00});
      chk({tag, "_be"},    {28'd0, bus.be}, {28'd0, be});
      chk({tag, "_wdata"}, bus.wdata, lanes);
      bus.gnt = 1;
      @(negedge clk); bus.gnt = 0;
      retire_now(tag);
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_rdy"},   {31'd0, in_ready}, 32'd1);
   endtask

   task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [4:0] rd, input logic [31:0] rdata,
                          input int gdly, input int rdly, input logic [3:0] be, input logic [31:0] exp);
      drive_mem(1, addr, size, uns, rd, 0);
      push(rd, exp, rd != 0, 0, 1);
      @(negedge clk); idle_in();
      for (int i = 0; i < gdly; i++) begin
         chk({tag, "_wait_req"},  {31'd0, bus.req}, 32'd1);
         chk({tag, "_wait_addr"}, bus.addr, {addr[31:2], 2'b00});
         chk({tag, "_wait_rdy"},  {31'd0, in_ready}, 32'd0);
         @(negedge clk);
      end
      chk({tag, "_req"},  {31'd0, bus.req}, 32'd1);
      chk({tag, "_we"},   {31'd0, bus.we}, 32'd0);
      chk({tag, "_addr"}, bus.addr, {addr[31:2], 2'b00});
      chk({tag, "_be"},   {28'd0, bus.be}, {28'd0, be});
      // Data offered alongside gnt must be ignored.
      bus.gnt = 1; bus.rvalid = 1; bus.rdata = 32'h5A5A_5A5A;
      @(negedge clk); bus.gnt = 0; bus.rvalid = 0;
      for (int i = 0; i < rdly; i++) begin
         chk({tag, "_resp_rdy"}, {31'd0, in_ready}, 32'd0);
         chk({tag, "_resp_req"}, {31'd0, bus.req}, 32'd0);
         chk({tag, "_resp_vld"}, {31'd0, out_valid}, 32'd0);
         @(negedge clk);
      end
      chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
      bus.rvalid = 1; bus.rdata = rdata;
      @(negedge clk); bus.rvalid = 0;
      retire_now(tag);
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_rdy"},   {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      bus.gnt = 0; bus.rvalid = 0; bus.rdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_req",   {31'd0, bus.req}, 32'd0);
      chk("rst_be",    {28'd0, bus.be}, 32'd0);
      chk("rst_val",   out_rd_val, 32'd0);
      rst = 1;

      // Non-memory ops, back to back
      @(negedge clk);
      in_valid = 1; in_rd_addr = 5'd5; in_rd_val = 32'h1234; in_wb_en = 1;
      push(5'd5, 32'h1234, 1, 0, 1);
      @(negedge clk);
      retire_now("alu0");
      chk("alu_b2b_rdy", {31'd0, in_ready}, 32'd1);
      in_rd_addr = 5'd6; in_rd_val = 32'hCAFE_0001;
      push(5'd6, 32'hCAFE_0001, 1, 0, 1);
      @(negedge clk);
      retire_now("alu1");
      in_rd_addr = 5'd0; in_rd_val = 32'h7;
      push(5'd0, 32'h7, 0, 0, 1);
      @(negedge clk);
      retire_now("alu_x0");
      idle_in();
      @(negedge clk);
      chk("alu_idle", {31'd0, out_valid}, 32'd0);

      // Stores
      do_store("st_b",  32'h0000_0103, 2'd0, 32'h0000_00AB, 0, 4'b1000, 32'hABAB_ABAB);
      do_store("st_h",  32'h0000_0102, 2'd1, 32'h1234_BEEF, 2, 4'b1100, 32'hBEEF_BEEF);
      do_store("st_w3", 32'h0000_0108, 2'd3, 32'h0102_0304, 1, 4'b1111, 32'h0102_0304);

      // Loads
      do_load("ld_hs", 32'h0000_0202, 2'd1, 0, 5'd7, 32'h8001_7FFF, 0, 0, 4'b1100, 32'hFFFF_8001);
      do_load("ld_hu", 32'h0000_0202, 2'd1, 1, 5'd7, 32'h8001_7FFF, 0, 0, 4'b1100, 32'h0000_8001);
      do_load("ld_bs", 32'h0000_0203, 2'd0, 0, 5'd8, 32'h8001_7FFF, 0, 0, 4'b1000, 32'hFFFF_FF80);
      do_load("ld_bu", 32'h0000_0201, 2'd0, 1, 5'd8, 32'h8001_7FFF, 0, 1, 4'b0010, 32'h0000_007F);
      do_load("ld_wd", 32'h0000_0400, 2'd2, 0, 5'd9, 32'hA5A5_1234, 3, 2, 4'b1111, 32'hA5A5_1234);
      do_load("ld_x0", 32'h0000_0404, 2'd2, 0, 5'd0, 32'h1111_2222, 0, 0, 4'b1111, 32'h1111_2222);

      // Response timeout, then the stage must accept again
      drive_mem(1, 32'h0000_0300, 2'd2, 0, 5'd9, 0);
      push(5'd9, 0, 0, 1, 0);
      @(negedge clk); idle_in(); bus.gnt = 1;
      @(negedge clk); bus.gnt = 0;
      wait_retire("tmo_resp", 10);
      @(negedge clk);
      chk("tmo_resp_rdy", {31'd0, in_ready}, 32'd1);

      // Grant timeout: request withdrawn
      drive_mem(0, 32'h0000_0310, 2'd2, 0, 5'd2, 32'h1);
      push(5'd2, 0, 0, 1, 0);
      @(negedge clk); idle_in();
      wait_retire("tmo_req", 10);
      chk("tmo_req_drop", {31'd0, bus.req}, 32'd0);
      in_valid = 1; in_rd_addr = 5'd10; in_rd_val = 32'h0BAD_F00D; in_wb_en = 1;
      push(5'd10, 32'h0BAD_F00D, 1, 0, 1);
      @(negedge clk); idle_in();
      retire_now("after_tmo");

      // Reset while in REQ
      drive_mem(0, 32'h0000_0500, 2'd2, 0, 5'd4, 32'h77);
      @(negedge clk); idle_in();
      chk("mid_req_before", {31'd0, bus.req}, 32'd1);
      rst = 0;
      #1;
      chk("mid_rst_req",   {31'd0, bus.req}, 32'd0);
      chk("mid_rst_rdy",   {31'd0, in_ready}, 32'd1);
      chk("mid_rst_addr",  bus.addr, 32'd0);
      chk("mid_rst_val",   out_rd_val, 32'd0);
      chk("mid_rst_rd",    {27'd0, out_rd_addr}, 32'd0);
      chk("mid_rst_wdata", bus.wdata, 32'd0);
      @(negedge clk); rst = 1;
      repeat (2) @(negedge clk);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("post_rst_req",   {31'd0, bus.req}, 32'd0);

      // Misaligned word at 0x102
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      drive_mem(1, 32'h0000_0102, 2'd2, 0, 5'd4, 0);
      push(5'd4, 0, 0, 0, 0);
      @(negedge clk); idle_in();
      retire_now("mis_trap");
      chk("mis_flag", {31'd0, out_misalign}, 32'd1);
      chk("mis_noreq", {31'd0, bus.req}, 32'd0);
      chk("mis_rdy", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("mis_flag_clr", {31'd0, out_misalign}, 32'd0);
`else
      do_load("mis_ld", 32'h0000_0102, 2'd2, 0, 5'd4, 32'hDEAD_0042, 0, 0, 4'b1111, 32'hDEAD_0042);
`endif

      chk("sb_drained", q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
